imem_ctrl: RTL and testbench

Access controller for the byte-addressable instruction memory of the single-cycle RISC-V core. It shares the memory's single port between the core's fetch path and a program loader. It turns each 32-bit loader word into a four-cycle big-endian byte-write burst and turns fetch requests into fixed-latency word reads. It sits between the PC/fetch logic, the loader interface and the instruction memory array, and asserts `core_hold` while the memory is being programmed.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/imem_wr_burst.sv | 69 ++++++
 rtl/imem_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory access controller.
//   imem_state_t : controller FSM states
//   NOP_INSTR    : instruction returned on a faulted fetch (addi x0, x0, 0)
//   addr_ok()    : word-aligned and a full word fits inside a memory of `bytes` bytes
package riscv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StRsp,
    StWr
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Checked on the full 32-bit address so high bits cannot alias into range.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned bytes);
    return (addr[1:0] == 2'b00) && (addr <= (bytes - 32'd4));
  endfunction

endpackage

// File: rtl/imem_wr_burst.sv
// Serializes one 32-bit word into four consecutive big-endian byte writes.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   start       : latch base/word and begin a burst (only while idle)
//   base        : byte address of the word (MSB goes here)
//   word        : word to write
//   we          : registered byte write enable, high for exactly 4 cycles
//   addr, wdata : registered byte address / data, base+bcnt and word byte (3-bcnt)
//   done        : last byte of the burst is on the bus this cycle
module imem_wr_burst #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [31:0]       word,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              done
);

  logic [1:0]        bcnt_q;
  logic [1:0]        bcnt_nxt;
  logic [ADDR_W-1:0] base_q;
  // The MSB goes out in the start cycle, so only the low three bytes are kept.
  logic [23:0]       word_q;
  logic [7:0]        byte_nxt;

  assign bcnt_nxt = bcnt_q + 2'd1;
  assign done     = we & (bcnt_q == 2'd3);

  always_comb begin
    byte_nxt = word_q[7:0];
    unique case (bcnt_nxt)
      2'd1:    byte_nxt = word_q[23:16];
      2'd2:    byte_nxt = word_q[15:8];
      default: byte_nxt = word_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt_q <= 2'd0;
      base_q <= '0;
      word_q <= '0;
      we     <= 1'b0;
      addr   <= '0;
      wdata  <= 8'h00;
    end else if (start) begin
      bcnt_q <= 2'd0;
      base_q <= base;
      word_q <= word[23:0];
      we     <= 1'b1;
      addr   <= base;
      wdata  <= word[31:24];
    end else if (we) begin
      if (bcnt_q == 2'd3) begin
        we <= 1'b0;
      end else begin
        bcnt_q <= bcnt_nxt;
        addr   <= base_q + {{(ADDR_W-2){1'b0}}, bcnt_nxt};
        wdata  <= byte_nxt;
      end
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Single-port instruction-memory access controller shared by fetch and loader.
// Ports:
//   clk, resetn                      : clock, asynchronous active-low reset
//   load_en                          : program mode (loader owns the port, core held)
//   ld_valid/ld_ready/ld_addr/ld_data: loader word handshake
//   ld_err                           : one-cycle pulse for a dropped loader word
//   fetch_req/fetch_ready/fetch_addr : fetch handshake
//   fetch_valid/fetch_instr/fetch_fault : fetch response (valid pulses one cycle)
//   core_hold                        : core must not advance the PC
//   mem_addr/mem_we/mem_wdata/mem_re/mem_rdata : memory array port
module imem_ctrl #(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES),
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_en,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_err,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_fault,
  output logic              core_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  import riscv_pkg::*;

  imem_state_t       state_q;
  logic              rd_fault_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic              ld_fire;
  logic              fetch_fire;
  logic              ld_ok;
  logic              fetch_ok;
  logic              bw_start;
  logic              bw_done;
  logic [ADDR_W-1:0] bw_addr;

  assign ld_ready    = (state_q == StIdle) & load_en;
  assign fetch_ready = (state_q == StIdle) & ~load_en;
  assign core_hold   = load_en | (state_q == StWr);

  assign ld_fire    = ld_valid & ld_ready;
  assign fetch_fire = fetch_req & fetch_ready;
  assign ld_ok      = addr_ok(ld_addr, MEM_BYTES);
  assign fetch_ok   = addr_ok(fetch_addr, MEM_BYTES);
  assign bw_start   = ld_fire & ld_ok;

  // Both address sources are registers; the burst owns the bus while it writes.
  assign mem_addr = mem_we ? bw_addr : rd_addr_q;

  imem_wr_burst #(
    .ADDR_W (ADDR_W)
  ) u_wr_burst (
    .clk    (clk),
    .resetn (resetn),
    .start  (bw_start),
    .base   (ld_addr[ADDR_W-1:0]),
    .word   (ld_data),
    .we     (mem_we),
    .addr   (bw_addr),
    .wdata  (mem_wdata),
    .done   (bw_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rd_fault_q  <= 1'b0;
      rd_addr_q   <= '0;
      mem_re      <= 1'b0;
      ld_err      <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_instr <= 32'h0;
    end else begin
      mem_re      <= 1'b0;
      ld_err      <= 1'b0;
      fetch_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ld_fire) begin
            if (ld_ok) state_q <= StWr;
            else       ld_err  <= 1'b1;
          end else if (fetch_fire) begin
            // A faulted fetch still walks RD/RSP so its latency matches a real read.
            state_q    <= StRd;
            rd_fault_q <= ~fetch_ok;
            if (fetch_ok) begin
              mem_re    <= 1'b1;
              rd_addr_q <= fetch_addr[ADDR_W-1:0];
            end
          end
        end
        StRd: state_q <= StRsp;
        StRsp: begin
          state_q     <= StIdle;
          fetch_valid <= 1'b1;
          fetch_fault <= rd_fault_q;
          fetch_instr <= rd_fault_q ? NOP_INSTR : mem_rdata;
        end
        StWr: begin
          if (bw_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: a byte-array memory model sits on the memory
// port, and an expected-contents array plus spec-level rules predict every response.
module tb_imem_ctrl;

  localparam int unsigned MEM_BYTES = 64;
  localparam int unsigned ADDR_W    = 6;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic              clk;
  logic              resetn;
  logic              load_en;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic              ld_err;
  logic              fetch_req;
  logic              fetch_ready;
  logic [31:0]       fetch_addr;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              fetch_fault;
  logic              core_hold;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              mem_re;
  logic [31:0]       mem_rdata;

  int n_cmp;
  int n_fail;

  logic [7:0] mem_arr  [MEM_BYTES];
  logic [7:0] init_arr [MEM_BYTES];
  logic [7:0] exp_mem  [MEM_BYTES];
  logic       init_mem;

  imem_ctrl #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .load_en     (load_en),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_err      (ld_err),
    .fetch_req   (fetch_req),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .core_hold   (core_hold),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array: byte writes, registered big-endian word reads.
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_arr[i] <= init_arr[i];
    end else if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
    if (mem_re) begin
      mem_rdata <= {mem_arr[mem_addr], mem_arr[6'(mem_addr + 6'd1)],
                    mem_arr[6'(mem_addr + 6'd2)], mem_arr[6'(mem_addr + 6'd3)]};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit model_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a <= MEM_BYTES - 4);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a);
    return {exp_mem[b], exp_mem[b+1], exp_mem[b+2], exp_mem[b+3]};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'(4 * $urandom_range(0, 15));
      2:       return 32'($urandom_range(0, 70));
      default: return $urandom | 32'h0000_0100;
    endcase
  endfunction

  // Present one loader word (load_en must already be 1); optionally drop load_en or
  // pulse reset at a given burst cycle.
  task automatic do_load(input logic [31:0] a, input logic [31:0] d,
                         input int drop_at, input int rst_at);
    bit ok;
    logic [7:0] b;
    logic [ADDR_W-1:0] ea;
    ok = model_ok(a);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready_offer: got %b want 1", ld_ready); end
    n_cmp++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_ready_in_load: got %b want 0", fetch_ready); end
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_addr = $urandom; ld_data = $urandom;
    if (!ok) begin
      @(negedge clk);
      n_cmp++; if (ld_err !== 1'b1) begin n_fail++; $display("FAIL ld_err_pulse a=%h: got %b want 1", a, ld_err); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ld_err_no_we a=%h: got %b want 0", a, mem_we); end
      n_cmp++; if (ld_ready !== load_en) begin n_fail++; $display("FAIL ld_err_idle: got %b want %b", ld_ready, load_en); end
      @(negedge clk);
      n_cmp++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL ld_err_one_cycle: got %b want 0", ld_err); end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        if (k == drop_at) load_en = 1'b0;
        if (k == rst_at) begin
          #2 resetn = 1'b0;
          @(negedge clk);
          n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we_drop: got %b want 0", mem_we); end
          n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
          n_cmp++; if (ld_ready !== load_en) begin n_fail++; $display("FAIL rst_idle: got %b want %b", ld_ready, load_en); end
          @(posedge clk); #1 resetn = 1'b1;
          @(negedge clk);
          n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume: got %b want 0", mem_we); end
          @(posedge clk); #1;
          return;
        end
        @(negedge clk);
        b  = 8'(d >> (8 * (3 - k)));
        ea = ADDR_W'(a + 32'(k));
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL burst_we k=%0d: got %b want 1", k, mem_we); end
        n_cmp++; if (mem_addr !== ea) begin n_fail++; $display("FAIL burst_addr k=%0d: got %h want %h", k, mem_addr, ea); end
        n_cmp++; if (mem_wdata !== b) begin n_fail++; $display("FAIL burst_data k=%0d: got %h want %h", k, mem_wdata, b); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL burst_ld_ready k=%0d: got %b want 0", k, ld_ready); end
        n_cmp++; if (core_hold !== 1'b1) begin n_fail++; $display("FAIL burst_hold k=%0d: got %b want 1", k, core_hold); end
        n_cmp++; if (mem_re !== 1'b0) begin n_fail++; $display("FAIL burst_no_re k=%0d: got %b want 0", k, mem_re); end
        exp_mem[int'(a) + k] = b;
      end
      @(negedge clk);
      n_cmp++; if (ld_ready !== load_en) begin n_fail++; $display("FAIL burst_end_ready: got %b want %b", ld_ready, load_en); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL burst_end_we: got %b want 0", mem_we); end
    end
    @(posedge clk); #1;
  endtask

  // One fetch with load_en already 0; checks the full N+1..N+3 timeline.
  task automatic do_fetch(input logic [31:0] a);
    bit ok;
    logic [31:0] exp;
    ok  = model_ok(a);
    exp = ok ? model_word(a) : NOP;
    fetch_req = 1'b1; fetch_addr = a;
    @(negedge clk);
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready_offer: got %b want 1", fetch_ready); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL ld_ready_in_fetch: got %b want 0", ld_ready); end
    @(posedge clk); #1;
    fetch_req = 1'b0; fetch_addr = $urandom;
    @(negedge clk);
    n_cmp++; if (mem_re !== ok) begin n_fail++; $display("FAIL fetch_re a=%h: got %b want %b", a, mem_re, ok); end
    if (ok) begin
      n_cmp++; if (mem_addr !== a[ADDR_W-1:0]) begin n_fail++; $display("FAIL fetch_addr: got %h want %h", mem_addr, a[ADDR_W-1:0]); end
    end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_no_we: got %b want 0", mem_we); end
    @(negedge clk);
    n_cmp++; if (fetch_valid !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL fetch_early: got valid=%b re=%b want 0 0", fetch_valid, mem_re); end
    @(negedge clk);
    n_cmp++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid a=%h: got %b want 1", a, fetch_valid); end
    n_cmp++; if (fetch_instr !== exp) begin n_fail++; $display("FAIL fetch_instr a=%h: got %h want %h", a, fetch_instr, exp); end
    n_cmp++; if (fetch_fault !== !ok) begin n_fail++; $display("FAIL fetch_fault a=%h: got %b want %b", a, fetch_fault, !ok); end
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready_again: got %b want 1", fetch_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({ld_ready, fetch_ready, core_hold} !== 3'b010) begin n_fail++; $display("FAIL reset_ready: got %b want 010", {ld_ready, fetch_ready, core_hold}); end
    n_cmp++; if ({mem_we, mem_re, ld_err, fetch_valid, fetch_fault} !== 5'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 00000", {mem_we, mem_re, ld_err, fetch_valid, fetch_fault}); end
    n_cmp++; if (fetch_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", fetch_instr); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    @(posedge clk); #1 resetn = 1'b1;
    load_en = 1'b1;
    @(negedge clk);
    n_cmp++; if ({ld_ready, fetch_ready, core_hold} !== 3'b101) begin n_fail++; $display("FAIL post_reset_load: got %b want 101", {ld_ready, fetch_ready, core_hold}); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_basic();
    load_en = 1'b1;
    do_load(32'd4, 32'h00F0_0093, -1, -1);
  endtask

  task automatic test_fetch_basic();
    load_en = 1'b0;
    do_fetch(32'd4);
    n_cmp++; if (fetch_instr !== 32'h00F0_0093) begin n_fail++; $display("FAIL fetch_hold_value: got %h want 00f00093", fetch_instr); end
  endtask

  task automatic test_faults();
    load_en = 1'b0;
    do_fetch(32'd6);
    do_fetch(32'd64);
    do_fetch(32'd68);
    do_fetch(32'hFFFF_FFFC);
    load_en = 1'b1;
    do_load(32'd61, $urandom, -1, -1);
    do_load(32'd64, $urandom, -1, -1);
    do_load(32'h0000_0104, $urandom, -1, -1);
  endtask

  task automatic test_simultaneous();
    load_en = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'd8; ld_data = $urandom;
    do_fetch(32'd8);
    ld_valid = 1'b0;
    load_en = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'd12;
    do_load(32'd8, $urandom, -1, -1);
    fetch_req = 1'b0;
  endtask

  task automatic test_load_en_drop();
    load_en = 1'b1;
    do_load(32'd20, $urandom, 2, -1);
    load_en = 1'b0;
    do_fetch(32'd20);
  endtask

  task automatic test_reset_mid_burst();
    load_en = 1'b1;
    do_load(32'd40, $urandom, -1, 2);
    load_en = 1'b0;
    do_fetch(32'd40);
  endtask

  task automatic test_back_to_back();
    load_en = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'd0;
    @(negedge clk);
    n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b want 1", fetch_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) fetch_addr = 32'((i + 1) * 4);
      else fetch_req = 1'b0;
      @(negedge clk);
      n_cmp++; if (mem_re !== 1'b1 || mem_addr !== 6'(i * 4)) begin n_fail++; $display("FAIL b2b_read i=%0d: got re=%b addr=%h want 1 %h", i, mem_re, mem_addr, 6'(i * 4)); end
      @(negedge clk);
      n_cmp++; if (fetch_ready !== 1'b0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_busy i=%0d: got ready=%b valid=%b want 0 0", i, fetch_ready, fetch_valid); end
      @(negedge clk);
      n_cmp++; if (fetch_valid !== 1'b1 || fetch_instr !== model_word(32'(i * 4))) begin n_fail++; $display("FAIL b2b_resp i=%0d: got valid=%b instr=%h want 1 %h", i, fetch_valid, fetch_instr, model_word(32'(i * 4))); end
      n_cmp++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d: got %b want 1", i, fetch_ready); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        load_en = 1'b1;
        do_load(rand_addr(), $urandom, -1, -1);
      end else begin
        load_en = 1'b0;
        do_fetch(rand_addr());
      end
    end
  endtask

  task automatic test_final_contents();
    int diffs;
    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (mem_arr[i] !== exp_mem[i]) diffs++;
    end
    n_cmp++; if (diffs != 0) begin n_fail++; $display("FAIL final_contents: got %0d differing bytes want 0", diffs); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    resetn = 1'b0; load_en = 1'b0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    fetch_req = 1'b0; fetch_addr = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      init_arr[i] = 8'($urandom);
      exp_mem[i]  = init_arr[i];
    end
    init_mem = 1'b1;
    @(posedge clk); #1 init_mem = 1'b0;
    test_reset();
    test_load_basic();
    test_fetch_basic();
    test_faults();
    test_simultaneous();
    test_load_en_drop();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    test_final_contents();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
